// File: rtl/multiplicador_pkg.sv
// rtl/multiplicador_pkg.sv - shared state encoding and counter sizing for the shift-and-add multiplier
package multiplicador_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/multiplicador_uc.sv
// rtl/multiplicador_uc.sv - shift-and-add multiplier control unit (Moore FSM)
// Option: MULTIPLICADOR_UC_HOLD_EN keeps done asserted until ack is sampled.
module multiplicador_uc
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  input  logic qlsb,
  input  logic zero,
  output logic a_rst,
  output logic a_en,
  output logic b_en,
  output logic q_en,
  output logic cnt_en,
  output logic a_ld,
  output logic b_ld,
  output logic q_ld,
  output logic cnt_ld,
  output logic busy,
  output logic done
);

  state_e state_q;
  state_e state_d;

  // The iteration count lives in the datapath counter; WIDTH is documentation here.
  logic unused_width;
  assign unused_width = WIDTH[0];

`ifndef MULTIPLICADOR_UC_HOLD_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_TEST;
      ST_TEST:  state_d = qlsb ? ST_ADD : ST_SHIFT;
      ST_ADD:   state_d = ST_SHIFT;
      // zero reflects the count before this shift's decrement.
      ST_SHIFT: state_d = zero ? ST_DONE : ST_TEST;
`ifdef MULTIPLICADOR_UC_HOLD_EN
      ST_DONE:  if (ack) state_d = ST_IDLE;
`else
      ST_DONE:  state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_rst  = 1'b0;
    a_en   = 1'b0;
    b_en   = 1'b0;
    q_en   = 1'b0;
    cnt_en = 1'b0;
    a_ld   = 1'b0;
    b_ld   = 1'b0;
    q_ld   = 1'b0;
    cnt_ld = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        a_rst  = 1'b1;
        b_en   = 1'b1;
        b_ld   = 1'b1;
        q_en   = 1'b1;
        q_ld   = 1'b1;
        cnt_en = 1'b1;
        cnt_ld = 1'b1;
        busy   = 1'b1;
      end
      ST_TEST: busy = 1'b1;
      ST_ADD: begin
        a_en = 1'b1;
        a_ld = 1'b1;
        busy = 1'b1;
      end
      ST_SHIFT: begin
        a_en   = 1'b1;
        q_en   = 1'b1;
        cnt_en = ~zero;
        busy   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multiplicador_uc.md
MULTIPLICADOR_UC -- requirements
Module: multiplicador_uc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; sets the loop count.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: request a multiplication; sampled only in IDLE.
REQ-005 SHALL have port ack, input, 1: result consumed; used only when MULTIPLICADOR_UC_HOLD_EN is defined, ignored otherwise.
REQ-006 SHALL have ports qlsb and zero, input, 1 each: datapath Q[0] and down-counter-is-zero status.
REQ-007 SHALL have ports a_rst, a_en, b_en, q_en, cnt_en, a_ld, b_ld, q_ld, cnt_ld, output, 1 each: datapath register/counter controls.
REQ-008 SHALL have ports busy and done, output, 1 each: operation in progress; result valid on P_out.

Function
REQ-009 SHALL be a Moore FSM with states IDLE, LOAD, TEST, ADD, SHIFT, DONE; all outputs decoded from current state only.
REQ-010 IDLE: all controls 0, busy=0, done=0; start=1 -> LOAD, else stay.
REQ-011 LOAD: b_en=b_ld=1, q_en=q_ld=1, cnt_en=cnt_ld=1 (counter loads WIDTH-1), a_rst=1 (one-cycle clear of A); busy=1; -> TEST unconditionally.
REQ-012 TEST: no controls, busy=1; qlsb=1 -> ADD, qlsb=0 -> SHIFT.
REQ-013 ADD: a_en=a_ld=1 (A <= A+B), busy=1; -> SHIFT unconditionally.
REQ-014 SHIFT: a_en=1, q_en=1 with a_ld=q_ld=0 (right shift {A,Q}, A[0] into Q msb), busy=1; zero=1 -> DONE with cnt_en=0; zero=0 -> cnt_en=1 (decrement) and -> TEST.
REQ-015 zero SHALL be evaluated on its pre-decrement value in SHIFT, giving exactly WIDTH shift iterations per operation.
REQ-016 DONE: done=1, busy=0, all controls 0; without HOLD_EN -> IDLE after exactly one cycle.
REQ-017 Latency, with cycle 0 the edge sampling start in IDLE and k the number of 1 bits in the multiplier: LOAD in cycle 1; done high in cycle 2+2*WIDTH+k.
REQ-018 start while busy or in DONE SHALL be ignored; no queuing.
REQ-019 start held high continuously SHALL begin a new operation on the cycle after DONE exits to IDLE (back-to-back).
REQ-020 Never assert any *_ld without its matching *_en; never assert a_ld and a_rst together.

Reset
REQ-021 rst=1 SHALL force IDLE immediately, asynchronously, regardless of state; all outputs 0 while rst is high.
REQ-022 Reset mid-operation SHALL abandon the operation; no done pulse is produced for it.
REQ-023 After rst falls, start is sampled on the first rising edge.

Configuration
REQ-024 Macro MULTIPLICADOR_UC_HOLD_EN defined: DONE holds done=1 until ack=1 is sampled, then -> IDLE; ack in any other state is ignored.
REQ-025 Macro undefined: done is a single-cycle pulse, ack is unconnected internally, behaviour as REQ-016.

Structure
REQ-026 Shared package multiplicador_pkg SHALL hold the state enum (3-bit encoding) and the count width constant $clog2(WIDTH); datapath and top-level integration reuse it.
REQ-027 SHALL be flat: no sub-module; integration with the datapath happens in a separate top-level multiplicador, outside this block.

Verification
REQ-028 WIDTH=8, pulse start, qlsb model of multiplier 0x00 -> 8 SHIFT, 0 ADD, done in cycle 18; P_out=0 with the datapath attached.
REQ-029 Multiplier 0xFF, multiplicand 0x03 -> 8 ADD, done in cycle 26, P_out=0x02FD.
REQ-030 Multiplier 0x01 -> exactly one ADD in the first iteration, done in cycle 19; busy high in cycles 1..18.
REQ-031 rst asserted in the cycle of the 3rd SHIFT -> all outputs 0 in the same cycle, IDLE; no done; a new start completes normally.
REQ-032 start pulsed during TEST/SHIFT -> ignored, latency unchanged; start held high -> two consecutive operations, LOAD one cycle after the first done.
REQ-033 With HOLD_EN defined, ack withheld 5 cycles -> done stays high 5 cycles; ack=1 -> IDLE on the next edge.
